// File: rtl/fp_mult_pipe.sv
// Pipelined IEEE-754 binary multiplier (unpack, normalise, round, pack) with a
// valid/ready handshake, four rounding modes, DAZ/FTZ and exception flags.
module fp_mult_pipe #(
   parameter  int EXP_WIDTH = 8,
   parameter  int SIG_WIDTH = 23,
   localparam int WIDTH     = 1 + EXP_WIDTH + SIG_WIDTH,
   localparam int BIAS      = 2**(EXP_WIDTH-1) - 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       rnd,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);
   localparam int EW = EXP_WIDTH + 2;
   localparam int PW = 2 * (SIG_WIDTH + 1);
   localparam logic signed [EW-1:0]  EXP_ZERO = '0;
   localparam logic signed [EW-1:0]  EXP_ONE  = EW'(1);
   localparam logic signed [EW-1:0]  EXP_MAX  = EW'(2**EXP_WIDTH - 1);
   localparam logic [EXP_WIDTH-1:0]  EXP_ONES = '1;

   typedef enum logic [1:0] {RNE = 2'b00, RTZ = 2'b01, RUP = 2'b10, RDN = 2'b11} rnd_t;
   typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

   logic adv;
   logic v1, v2, v3;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Unpack: a zero exponent field covers both zero and subnormal (flushed).
   logic [EXP_WIDTH-1:0] ea, eb;
   logic [SIG_WIDTH-1:0] fa, fb;
   logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic signed [EW-1:0] exp_sum;
   logic [PW-1:0]        prod;
   special_t             sp_d;
   logic                 inv_d;

   assign ea      = A[WIDTH-2:SIG_WIDTH];
   assign eb      = B[WIDTH-2:SIG_WIDTH];
   assign fa      = A[SIG_WIDTH-1:0];
   assign fb      = B[SIG_WIDTH-1:0];
   assign a_zero  = (ea == '0);
   assign b_zero  = (eb == '0);
   assign a_inf   = (ea == EXP_ONES) && (fa == '0);
   assign b_inf   = (eb == EXP_ONES) && (fb == '0);
   assign a_nan   = (ea == EXP_ONES) && (fa != '0);
   assign b_nan   = (eb == EXP_ONES) && (fb != '0);
   assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(EW'(BIAS));
   assign prod    = PW'({1'b1, fa}) * PW'({1'b1, fb});

   always_comb begin
      sp_d  = SP_NONE;
      inv_d = 1'b0;
      if (a_nan || b_nan) begin
         sp_d = SP_NAN;
      end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
         sp_d  = SP_NAN;
         inv_d = 1'b1;
      end else if (a_inf || b_inf) begin
         sp_d = SP_INF;
      end else if (a_zero || b_zero) begin
         sp_d = SP_ZERO;
      end
   end

   logic                 s1_sign, s1_inv;
   logic signed [EW-1:0] s1_exp;
   logic [PW-1:0]        s1_prod;
   rnd_t                 s1_rnd;
   special_t             s1_sp;

   // Normalise: product lies in [1,4); the top bit set means [2,4).
   logic signed [EW-1:0] norm_exp;
   logic [SIG_WIDTH-1:0] norm_frac;
   logic                 norm_g, norm_st;

   always_comb begin
      norm_exp  = s1_exp;
      norm_frac = s1_prod[PW-3:SIG_WIDTH];
      norm_g    = s1_prod[SIG_WIDTH-1];
      norm_st   = |s1_prod[SIG_WIDTH-2:0];
      if (s1_prod[PW-1]) begin
         norm_exp  = s1_exp + EXP_ONE;
         norm_frac = s1_prod[PW-2:SIG_WIDTH+1];
         norm_g    = s1_prod[SIG_WIDTH];
         norm_st   = |s1_prod[SIG_WIDTH-1:0];
      end
   end

   logic                 s2_sign, s2_inv, s2_g, s2_st;
   logic signed [EW-1:0] s2_exp;
   logic [SIG_WIDTH-1:0] s2_frac;
   rnd_t                 s2_rnd;
   special_t             s2_sp;

   logic                 round_up;
   logic [SIG_WIDTH:0]   frac_sum;
   logic signed [EW-1:0] round_exp;

   always_comb begin
      round_up = 1'b0;
      case (s2_rnd)
         RNE: round_up = s2_g && (s2_st || s2_frac[0]);
         RTZ: round_up = 1'b0;
         RUP: round_up = !s2_sign && (s2_g || s2_st);
         RDN: round_up = s2_sign && (s2_g || s2_st);
         default: round_up = 1'b0;
      endcase
   end

   // A carry out of the fraction leaves it all zeros and bumps the exponent.
   assign frac_sum  = {1'b0, s2_frac} + (SIG_WIDTH+1)'(round_up);
   assign round_exp = s2_exp + $signed({{(EW-1){1'b0}}, frac_sum[SIG_WIDTH]});

   logic                 s3_sign, s3_inv, s3_inexact, s3_unf;
   logic signed [EW-1:0] s3_exp;
   logic [SIG_WIDTH-1:0] s3_frac;
   rnd_t                 s3_rnd;
   special_t             s3_sp;

   logic             ovf, to_inf;
   logic [WIDTH-1:0] res_d;
   logic [3:0]       flags_d;

   assign ovf    = !s3_unf && (s3_exp >= EXP_MAX);
   assign to_inf = (s3_rnd == RNE) || (s3_rnd == RUP && !s3_sign) || (s3_rnd == RDN && s3_sign);

   always_comb begin
      res_d   = {s3_sign, s3_exp[EXP_WIDTH-1:0], s3_frac};
      flags_d = {3'b000, s3_inexact};
      case (s3_sp)
         SP_NAN: begin
            res_d   = {1'b0, EXP_ONES, 1'b1, {(SIG_WIDTH-1){1'b0}}};
            flags_d = {s3_inv, 3'b000};
         end
         SP_INF: begin
            res_d   = {s3_sign, EXP_ONES, {SIG_WIDTH{1'b0}}};
            flags_d = '0;
         end
         SP_ZERO: begin
            res_d   = {s3_sign, {(WIDTH-1){1'b0}}};
            flags_d = '0;
         end
         default: begin
            if (s3_unf) begin
               // The product of two normals is never zero, so flushing is always inexact.
               res_d   = {s3_sign, {(WIDTH-1){1'b0}}};
               flags_d = 4'b0011;
            end else if (ovf) begin
               res_d   = to_inf ? {s3_sign, EXP_ONES, {SIG_WIDTH{1'b0}}}
                                : {s3_sign, EXP_ONES - 1'b1, {SIG_WIDTH{1'b1}}};
               flags_d = 4'b0101;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
      end else if (adv) begin
         v1        <= in_valid;
         v2        <= v1;
         v3        <= v2;
         out_valid <= v3;
         if (v3) begin
            result <= res_d;
            flags  <= flags_d;
         end
      end
   end

   // NOTE: stage data registers carry no reset; the valid bits alone say whether they mean anything.
   always_ff @(posedge clk) begin
      if (adv) begin
         s1_sign    <= A[WIDTH-1] ^ B[WIDTH-1];
         s1_exp     <= exp_sum;
         s1_prod    <= prod;
         s1_rnd     <= rnd_t'(rnd);
         s1_sp      <= sp_d;
         s1_inv     <= inv_d;

         s2_sign    <= s1_sign;
         s2_exp     <= norm_exp;
         s2_frac    <= norm_frac;
         s2_g       <= norm_g;
         s2_st      <= norm_st;
         s2_rnd     <= s1_rnd;
         s2_sp      <= s1_sp;
         s2_inv     <= s1_inv;

         s3_sign    <= s2_sign;
         s3_exp     <= round_exp;
         s3_frac    <= frac_sum[SIG_WIDTH-1:0];
         s3_inexact <= s2_g || s2_st;
         s3_unf     <= (s2_exp <= EXP_ZERO);
         s3_rnd     <= s2_rnd;
         s3_sp      <= s2_sp;
         s3_inv     <= s2_inv;
      end
   end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
Parametrised, pipelined IEEE-754 binary floating-point multiplier. It succeeds the fixed 32-bit `top` multiplier.
- Generalised over exponent and significand width.
- Adds a valid/ready handshake with back-pressure, four rounding modes and exception flags.
- Sits between operand sources and the result FIFO in the FP datapath. Fixed latency of 3 cycles when not stalled.

Parameters:
EXP_WIDTH, 8, exponent field width (binary32 = 8, binary64 = 11, binary16 = 5)
SIG_WIDTH, 23, stored fraction width, hidden bit excluded
WIDTH, 1+EXP_WIDTH+SIG_WIDTH, operand/result width; derived, do not override
BIAS, 2**(EXP_WIDTH-1)-1, exponent bias; derived

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low (rst==0 at a clk edge resets)
in_valid  in  1  operands A, B and rnd are valid
in_ready  out  1  block accepts operands this cycle
A  in  WIDTH  operand A
B  in  WIDTH  operand B
rnd  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf)
out_valid  out  1  result and flags are valid
out_ready  in  1  consumer accepts the result
result  out  WIDTH  packed product
flags  out  4  {invalid, overflow, underflow, inexact}, per result

Behaviour:
- Reset values: out_valid=0, result=0, flags=0, all stage valid bits=0. Stage data registers are don't-care.
- Reset mid-operation discards all in-flight operations. There is no output on the cycle after reset is released.
- Pipeline advance: `adv = !out_valid || out_ready`. All three stages move together; there is no bubble squeezing.
- in_ready = adv, combinational.
- Acceptance: an input is taken when in_valid && in_ready.
- Output hold: while out_valid && !out_ready, result and flags hold stable.
- Latency: an operation accepted at edge N appears with out_valid=1 after edge N+3 when unstalled. Throughput is 1 per cycle.
- S1 (unpack):
  - Classify each operand as zero, subnormal, normal, inf or NaN.
  - Subnormal inputs are flushed to signed zero (DAZ).
  - sign = sA ^ sB.
  - Exponent sum eA+eB-BIAS, kept as a signed value of width EXP_WIDTH+2.
  - Significand product of width 2*(SIG_WIDTH+1), both hidden bits set.
  - rnd and the special-case class are registered alongside.
- S2 (normalise):
  - If the product MSB is 1: shift right 1 and increment the exponent.
  - Extract the SIG_WIDTH fraction bits, a guard bit and a sticky bit (OR of all lower bits).
- S3 (round, pack):
  - Round-up condition by mode:
    - RNE: g && (sticky || lsb).
    - RTZ: never.
    - RUP: !sign && (g || sticky).
    - RDN: sign && (g || sticky).
  - Mantissa carry-out from rounding increments the exponent and zeroes the fraction.
  - inexact = g || sticky, before the special-case override.
- Overflow (biased exponent >= 2**EXP_WIDTH-1 after rounding):
  - Result is inf if the mode rounds away: RNE always; RUP when positive; RDN when negative.
  - Otherwise the result is the max finite value of that sign.
  - overflow=1 and inexact=1.
- Underflow (biased exponent <= 0 after normalise):
  - Result is signed zero (FTZ) in all modes.
  - underflow=1; inexact=1 if the dropped value is nonzero.
- Special-case priority, which overrides all arithmetic and clears overflow, underflow and inexact:
  1. NaN operand -> canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0), invalid=0 unless it is inf*0.
  2. inf*0 -> canonical qNaN, invalid=1.
  3. inf*x -> signed inf.
  4. 0*x -> signed zero.
- Signalling NaNs are not distinguished from quiet NaNs.

Test Plan:
- Basic product, binary32, RNE: A=3FC00000, B=40000000 -> after 3 cycles result=40400000, flags=0000.
- Rounding modes: A=B=3F800001.
  - RNE -> 3F800002, inexact=1.
  - RTZ -> 3F800002.
  - RUP -> 3F800003.
  - With A=BF800001, RDN -> BF800003.
- Overflow: A=B=7F000000.
  - RNE -> 7F800000, flags=0101.
  - RTZ -> 7F7FFFFF, flags=0101.
- Specials and FTZ:
  - 7F800000*00000000 -> 7FC00000, invalid=1.
  - 00800000*3F000000 -> 00000000, flags=0011.
  - 80000000*3F800000 -> 80000000.
- Back-pressure:
  - Stream 8 back-to-back ops, hold out_ready=0 for 4 cycles mid-stream.
  - Required: in_ready=0 throughout, output held stable, no loss or duplication.
  - Results emerge in order once out_ready=1.
- Reset and parametrisation:
  - Drive rst=0 with 2 ops in flight -> out_valid=0 the next cycle and neither op ever emerges.
  - Repeat directed cases at EXP_WIDTH=5, SIG_WIDTH=10: 3C00*4000 -> 4000.
